// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is
// split into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each pipeline stage
// resolves one chunk using the carry registered by the stage before it, so no
// single cycle carries more than CHUNK bits of ripple.
//
// Flow control is valid/ready with bubble collapsing: a stage may load when it
// is empty or when the stage below it is moving. in_ready is therefore a
// combinational function of out_ready and the stage valid bits.
//
// Parameters:
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth, 1 <= STAGES <= WIDTH (latency = STAGES cycles)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; flushes all in-flight work
//   in_valid   operand transaction valid
//   in_ready   block can accept a transaction this cycle
//   a, b       operands
//   sub        0: a+b, 1: a-b (sampled with the operands)
//   out_valid  result valid; holds with stable data until consumed
//   out_ready  downstream accepts the result
//   sum        result modulo 2^WIDTH (clamped when saturation is built in)
//   co         carry out of the MSB; for subtract 1 means no borrow
//   ovf        signed overflow of the unsaturated result
//
// Build option:
//   ADDER_PIPE_SAT_EN  when defined, sum is clamped to the signed extreme on
//                      overflow (0x7F..F for non-negative a, 0x80..0 for
//                      negative a). co and ovf still describe the raw add.
//                      Clamping happens in the final stage; latency is the
//                      same either way.
// -----------------------------------------------------------------------------
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // ---------------------------------------------------------------------------
  // Stage state. Every stage carries the full-width operands and the partial
  // result; chunks below k are already resolved in res_q[k], chunk k is the one
  // stage k just added, and the chunks above are still waiting in opa/opb.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic              ovf_q;

  // What each stage would load from above: the input port for stage 0, the
  // previous stage's registers for the rest.
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_res [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  nxt_res [STAGES];
  logic              ovf_nxt;

  // ---------------------------------------------------------------------------
  // Operand conditioning: subtract is a + ~b + 1, with the +1 entering as the
  // carry into chunk 0.
  // ---------------------------------------------------------------------------
  assign src_v[0]   = in_valid;
  assign src_c[0]   = sub;
  assign src_res[0] = '0;
  assign src_a[0]   = a;
  assign src_b[0]   = sub ? ~b : b;

  for (genvar k = 1; k < STAGES; k++) begin : g_src
    assign src_v[k]   = v_q[k-1];
    assign src_c[k]   = c_q[k-1];
    assign src_res[k] = res_q[k-1];
    assign src_a[k]   = opa_q[k-1];
    assign src_b[k]   = opb_q[k-1];
  end

  // ---------------------------------------------------------------------------
  // Bubble-collapsing enables. A stage can load if it is empty or if whatever
  // it holds is leaving this cycle. Walking from the output back to the input
  // keeps the chain free of any self-reference.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic e;
    // NOTE: every variable driven here gets a value before any branch or loop,
    // so no path can leave it holding its old value and infer a latch.
    en = '0;
    e  = !v_q[STAGES-1] || out_ready;
    en[STAGES-1] = e;
    for (int k = STAGES - 2; k >= 0; k--) begin
      e     = !v_q[k] || e;
      en[k] = e;
    end
  end

  assign in_ready = en[0];

  // ---------------------------------------------------------------------------
  // Per-stage chunk adder. Stage k only ever touches bits
  // [k*CHUNK +: CHUNK]; everything else in the result is passed through.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [CHUNK:0] t;
    t       = '0;
    nxt_c   = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
        + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, src_c[k]};
      nxt_res[k]                   = src_res[k];
      nxt_res[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      nxt_c[k]                     = t[CHUNK];
    end

    // Signed overflow: both addends share a sign and the result's sign differs.
    // This uses the conditioned b, so it also covers subtraction.
    ovf_nxt = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
              (nxt_res[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);

`ifdef ADDER_PIPE_SAT_EN
    // Overflow direction follows the sign of a: a positive a can only overflow
    // upward, a negative a only downward.
    if (ovf_nxt) begin
      nxt_res[STAGES-1] = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    // Wrapping build: the final stage result is used as computed.
`endif
  end

  // ---------------------------------------------------------------------------
  // Stage registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      // NOTE: the datapath registers are reset along with the valid bits
      // because sum/co/ovf are read straight from the last stage and must
      // show zero out of reset, not whatever the flops powered up with.
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge; blocking ones here would shoot a
      // transaction through several stages in one cycle.
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= src_v[k];
          // Data only moves with a real transaction; bubbles leave it alone.
          if (src_v[k]) begin
            res_q[k] <= nxt_res[k];
            opa_q[k] <= src_a[k];
            opb_q[k] <= src_b[k];
            c_q[k]   <= nxt_c[k];
          end
        end
      end
      if (en[STAGES-1] && src_v[STAGES-1]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the final stage.
  // ---------------------------------------------------------------------------
  assign out_valid = v_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
